// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared op encodings, FSM state type and op-class helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [4:0] OP_AND   = 5'd0;
    localparam logic [4:0] OP_OR    = 5'd1;
    localparam logic [4:0] OP_XOR   = 5'd2;
    localparam logic [4:0] OP_NOR   = 5'd3;
    localparam logic [4:0] OP_ADD   = 5'd4;
    localparam logic [4:0] OP_SUB   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;
    localparam logic [4:0] OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_MFHI  = 5'd11;
    localparam logic [4:0] OP_MFLO  = 5'd12;
    localparam logic [4:0] OP_MULT  = 5'd13;
    localparam logic [4:0] OP_MULTU = 5'd14;
    localparam logic [4:0] OP_DIV   = 5'd15;
    localparam logic [4:0] OP_DIVU  = 5'd16;
    localparam logic [4:0] OP_MTHI  = 5'd17;
    localparam logic [4:0] OP_MTLO  = 5'd18;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Ops that occupy the multi-cycle multiply/divide unit
    function automatic logic is_mdu_op(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_comb.sv
// ============================================================================
// Module  : alu_comb
// Brief   : Single-cycle ALU: logic, add/sub with raw overflow, compares,
//           shifts and HI/LO moves.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] c,
    output logic             ov
);

    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH:0]  w_sum;
    logic [WIDTH:0]  w_diff;
    logic [SH_W-1:0] w_shamt;

    // One extra sign bit lets overflow be read as a disagreement of the top two bits
    assign w_sum   = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign w_diff  = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    assign w_shamt = a[SH_W-1:0];

    always_comb begin
        c  = '0;
        ov = 1'b0;
        case (op)
            OP_AND:  c = a & b;
            OP_OR:   c = a | b;
            OP_XOR:  c = a ^ b;
            OP_NOR:  c = ~(a | b);
            OP_ADD: begin
                c  = w_sum[WIDTH-1:0];
                ov = w_sum[WIDTH] ^ w_sum[WIDTH-1];
            end
            OP_SUB: begin
                c  = w_diff[WIDTH-1:0];
                ov = w_diff[WIDTH] ^ w_diff[WIDTH-1];
            end
            OP_SLT:  c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: c = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  c = b << w_shamt;
            OP_SRL:  c = b >> w_shamt;
            OP_SRA:  c = $signed(b) >>> w_shamt;
            OP_MFHI: c = hi;
            OP_MFLO: c = lo;
            default: c = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_mdu.sv
// ============================================================================
// Module  : alu_mdu
// Brief   : ALU plus fixed-latency multiply/divide unit with HI/LO registers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       op,
    input  logic             start,
    input  logic             arith_ov_en,
    input  logic             dm_ov_en,
    output logic [WIDTH-1:0] c,
    output logic             alu_ov,
    output logic             dm_ov,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [WIDTH-1:0] C_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] C_ONES = {WIDTH{1'b1}};

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [4:0]         r_op;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;

    logic               w_ov;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a  (a),
        .b  (b),
        .op (op),
        .hi (r_hi),
        .lo (r_lo),
        .c  (c),
        .ov (w_ov)
    );

    assign alu_ov = w_ov & arith_ov_en;
    assign dm_ov  = w_ov & dm_ov_en;
    assign busy   = r_busy;
    assign hi     = r_hi;
    assign lo     = r_lo;

    // Result is formed from the latched operands; the counter only sets when it is taken
    assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
    assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (r_op)
            OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            OP_DIV: begin
                if (r_b == '0) begin
                    w_res_lo = C_ONES;
                    w_res_hi = r_a;
                end else if ((r_a == C_MIN) && (r_b == C_ONES)) begin
                    w_res_lo = C_MIN;
                    w_res_hi = '0;
                end else begin
                    w_res_lo = $signed(r_a) / $signed(r_b);
                    w_res_hi = $signed(r_a) % $signed(r_b);
                end
            end
            OP_DIVU: begin
                if (r_b == '0) begin
                    w_res_lo = C_ONES;
                    w_res_hi = r_a;
                end else begin
                    w_res_lo = r_a / r_b;
                    w_res_hi = r_a % r_b;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_mdu_op(op)) begin
                            r_a     <= a;
                            r_b     <= b;
                            r_op    <= op;
                            r_cnt   <= ((op == OP_MULT) || (op == OP_MULTU)) ?
                                       CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
                            r_busy  <= 1'b1;
                            r_state <= ST_RUN;
                        end else if (op == OP_MTHI) begin
                            r_hi <= a;
                        end else if (op == OP_MTLO) begin
                            r_lo <= a;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu.sv
// ============================================================================
// Module  : tb_alu_mdu
// Brief   : Scoreboard bench for alu_mdu (32-bit default plus a 16-bit instance).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mdu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic [4:0]  op;
    logic        start, arith_ov_en, dm_ov_en;
    logic [31:0] c, hi, lo;
    logic        alu_ov, dm_ov, busy;

    logic [15:0] a16, b16, c16, hi16, lo16;
    logic [4:0]  op16;
    logic        start16, alu_ov16, dm_ov16, busy16;

    always #5 clk = ~clk;

    alu_mdu dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .start(start),
        .arith_ov_en(arith_ov_en), .dm_ov_en(dm_ov_en), .c(c),
        .alu_ov(alu_ov), .dm_ov(dm_ov), .busy(busy), .hi(hi), .lo(lo)
    );

    alu_mdu #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(3)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .op(op16), .start(start16),
        .arith_ov_en(1'b1), .dm_ov_en(1'b1), .c(c16),
        .alu_ov(alu_ov16), .dm_ov(dm_ov16), .busy(busy16), .hi(hi16), .lo(lo16)
    );

    typedef struct {
        string       name;
        logic [31:0] c;
        logic        aov;
        logic        dov;
    } comb_exp_t;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } mdu_exp_t;

    comb_exp_t cq[$];
    mdu_exp_t  mq[$];
    logic      chk_c = 1'b0;
    int        errors = 0;
    int        checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: comb results on chk_c strobes, HI/LO plus latency on each busy fall
    initial begin
        comb_exp_t ce;
        mdu_exp_t  me;
        int        run = 0;
        logic      prev = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_c) begin
                if (cq.size() == 0) chk("comb_queue_empty", 1, 0);
                else begin
                    ce = cq.pop_front();
                    chk({ce.name, "_c"}, c, ce.c);
                    chk({ce.name, "_alu_ov"}, alu_ov, ce.aov);
                    chk({ce.name, "_dm_ov"}, dm_ov, ce.dov);
                end
            end
            if (!rst_n) begin
                prev = 1'b0;
                run  = 0;
            end else if (busy) begin
                run++;
                prev = 1'b1;
            end else if (prev) begin
                prev = 1'b0;
                if (mq.size() == 0) chk("mdu_queue_empty", 1, 0);
                else begin
                    me = mq.pop_front();
                    chk({me.name, "_hi"}, hi, me.hi);
                    chk({me.name, "_lo"}, lo, me.lo);
                    chk({me.name, "_busy_cycles"}, run, me.lat);
                end
                run = 0;
            end
        end
    end

    task automatic comb_check(input string name, input logic [4:0] o, input logic [31:0] aa,
                              input logic [31:0] bb, input logic aen, input logic den,
                              input logic [31:0] ec, input logic eaov, input logic edov);
        comb_exp_t e;
        e.name = name; e.c = ec; e.aov = eaov; e.dov = edov;
        op = o; a = aa; b = bb; arith_ov_en = aen; dm_ov_en = den;
        cq.push_back(e);
        chk_c = 1'b1;
        @(posedge clk); #1;
        chk_c = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!busy) return;
            @(posedge clk); #1;
        end
        chk("busy_timeout", busy, 0);
    endtask

    task automatic mdu_op(input string name, input logic [4:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [31:0] ehi,
                          input logic [31:0] elo, input int lat);
        mdu_exp_t e;
        e.name = name; e.hi = ehi; e.lo = elo; e.lat = lat;
        op = o; a = aa; b = bb; start = 1'b1;
        mq.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
    endtask

    task automatic move_to(input logic [4:0] o, input logic [31:0] aa);
        op = o; a = aa; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        mdu_exp_t e;
        rst_n = 1'b0; a = '0; b = '0; op = OP_AND; start = 1'b0;
        arith_ov_en = 1'b0; dm_ov_en = 1'b0;
        a16 = '0; b16 = '0; op16 = OP_AND; start16 = 1'b0;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 16-bit instance: shift and one-cycle multiply
        op16 = OP_SRA; a16 = 16'd4; b16 = 16'h8000; #1;
        chk("w16_sra", c16, 16'hF800);
        op16 = OP_MULT; a16 = 16'hFFFD; b16 = 16'd7; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        chk("w16_busy_after_accept", busy16, 1);
        @(posedge clk); #1;
        chk("w16_busy_done", busy16, 0);
        chk("w16_mult_hi", hi16, 16'hFFFF);
        chk("w16_mult_lo", lo16, 16'hFFEB);

        comb_check("and",  OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 0, 32'h00F0_1200, 0, 0);
        comb_check("or",   OP_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 0, 0, 32'hFFF0_FF34, 0, 0);
        comb_check("xor",  OP_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 0, 32'hFF00_ED34, 0, 0);
        comb_check("nor",  OP_NOR, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 0, 32'h000F_00CB, 0, 0);
        comb_check("add_ov_en",  OP_ADD, 32'h7FFF_FFFF, 32'd1, 1, 0, 32'h8000_0000, 1, 0);
        comb_check("add_ov_dis", OP_ADD, 32'h7FFF_FFFF, 32'd1, 0, 0, 32'h8000_0000, 0, 0);
        comb_check("sub_dm_ov",  OP_SUB, 32'h8000_0000, 32'd1, 0, 1, 32'h7FFF_FFFF, 0, 1);
        comb_check("add_no_ov",  OP_ADD, 32'hFFFF_FFFF, 32'd1, 1, 1, 32'h0000_0000, 0, 0);
        comb_check("slt",  OP_SLT,  32'hFFFF_FFFF, 32'd1, 0, 0, 32'd1, 0, 0);
        comb_check("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 0, 0, 32'd0, 0, 0);
        comb_check("sll_wrap_amt", OP_SLL, 32'd36, 32'd1, 0, 0, 32'h10, 0, 0);
        comb_check("srl",  OP_SRL, 32'd31, 32'h8000_0000, 0, 0, 32'd1, 0, 0);
        comb_check("sra",  OP_SRA, 32'd4,  32'h8000_0000, 0, 0, 32'hF800_0000, 0, 0);
        comb_check("undef_op", 5'd31, 32'h7FFF_FFFF, 32'd1, 1, 1, 32'd0, 0, 0);

        mdu_op("mult",  OP_MULT,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
        mdu_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 5);
        mdu_op("div_neg",  OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        mdu_op("div_zero", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 10);
        mdu_op("div_ovf",  OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
        mdu_op("divu",     OP_DIVU, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999, 10);

        move_to(OP_MTHI, 32'hCAFE);
        comb_check("mfhi_after_mthi", OP_MFHI, 32'd0, 32'd0, 0, 0, 32'hCAFE, 0, 0);
        move_to(OP_MTLO, 32'hBEEF);
        comb_check("mflo_after_mtlo", OP_MFLO, 32'd0, 32'd0, 0, 0, 32'hBEEF, 0, 0);

        // Non-sequential op with start must not disturb anything
        op = OP_ADD; a = 32'h1; b = 32'h1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_nonseq_busy", busy, 0);

        // MULT then MTHI while busy; operands change mid-run
        e.name = "mult_then_mthi"; e.hi = 32'd0; e.lo = 32'd42; e.lat = 5;
        mq.push_back(e);
        op = OP_MULT; a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        op = OP_MTHI; a = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0;
        comb_check("mflo_while_busy", OP_MFLO, 32'hDEAD_0000, 32'h5555_AAAA, 0, 0, 32'hBEEF, 0, 0);
        wait_idle();
        comb_check("mfhi_mthi_ignored", OP_MFHI, 32'd0, 32'd0, 0, 0, 32'd0, 0, 0);

        // Asynchronous reset mid-divide
        move_to(OP_MTHI, 32'h55);
        op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("div_in_flight_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_hi", hi, 0);
        chk("async_rst_lo", lo, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mdu_op("mult_after_rst", OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5);

        repeat (3) @(posedge clk);
        chk("comb_queue_drained", cq.size(), 0);
        chk("mdu_queue_drained", mq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width (>=8).
REQ-002 Parameter MUL_LAT, default 5, cycles from multiply accept to HI/LO valid (>=1).
REQ-003 Parameter DIV_LAT, default 10, cycles from divide accept to HI/LO valid (>=1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 a  input  WIDTH  operand A; also the shift amount (low log2(WIDTH) bits).
REQ-007 b  input  WIDTH  operand B; the shifted value for shift ops.
REQ-008 op  input  5  operation select; encodings come from the shared package.
REQ-009 start  input  1  single-cycle request for a sequential op (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
REQ-010 arith_ov_en  input  1  enables alu_ov.
REQ-011 dm_ov_en  input  1  enables dm_ov (address-calculation overflow).
REQ-012 c  output  WIDTH  combinational result.
REQ-013 alu_ov  output  1  signed ADD/SUB overflow, gated by arith_ov_en.
REQ-014 dm_ov  output  1  signed ADD/SUB overflow, gated by dm_ov_en.
REQ-015 busy  output  1  multiply/divide in progress.
REQ-016 hi, lo  output  WIDTH each  registered HI/LO.

Function
REQ-017 Combinational ops SHALL be AND, OR, XOR, NOR, ADD, SUB, SLT (signed), SLTU, SLL, SRL and SRA, with c valid in the same cycle; c SHALL be 0 for any op not listed.
REQ-018 Overflow SHALL be computed on a (WIDTH+1)-bit sign-extended sum or difference, as bit WIDTH != bit WIDTH-1; it SHALL be 0 for ops other than ADD/SUB.
REQ-019 MFHI/MFLO SHALL drive c = hi / lo, both legal while busy (they show the old value).
REQ-020 start with busy=0 and op in MULT/MULTU/DIV/DIVU SHALL latch a, b and op, set busy, and load a down-counter with MUL_LAT or DIV_LAT.
REQ-021 FSM states are IDLE and RUN: IDLE->RUN on an accepted start; RUN->IDLE when the counter reaches 1.
REQ-022 On the RUN->IDLE edge, hi/lo SHALL update and busy SHALL fall, so results are visible exactly LAT cycles after the accepting edge.
REQ-023 MULT/MULTU SHALL produce a 2*WIDTH product, signed or unsigned: hi = upper half, lo = lower half.
REQ-024 DIV/DIVU SHALL give lo = quotient and hi = remainder, truncating toward zero; the remainder takes the sign of the dividend.
REQ-025 Divide by zero SHALL give lo = all ones and hi = dividend, with no flag.
REQ-026 Signed overflow (most-negative / -1) SHALL give lo = most-negative and hi = 0.
REQ-027 start with MTHI/MTLO and busy=0 SHALL write a into hi/lo on that edge; busy SHALL stay 0.
REQ-028 Any start while busy=1 SHALL be ignored: no state change and no latch.
REQ-029 start with a non-sequential op SHALL be ignored.
REQ-030 Operand inputs changing during RUN SHALL NOT affect the result.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, busy=0, hi=0, lo=0 and counter=0, aborting any operation in flight.
REQ-032 After rst_n deasserts, the first edge SHALL be able to accept a start.

Structure
REQ-033 The op encodings (5-bit constants) and the state typedef SHALL live in the shared package alu_pkg, also used by the decoder.
REQ-034 Combinational ALU logic SHALL be one sub-module, alu_comb; the sequential part (FSM, counter, HI/LO, arithmetic) is in alu_mdu.

Verification
REQ-035 ADD a=32'h7FFFFFFF, b=1, arith_ov_en=1 -> c=32'h80000000, alu_ov=1, dm_ov=0; repeat with arith_ov_en=0 -> alu_ov=0.
REQ-036 MULT a=-3, b=7 with start -> busy high for 5 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=1.
REQ-037 DIV a=-7, b=2 -> lo=-3, hi=-1 after 10 cycles; DIV a=5, b=0 -> lo=32'hFFFFFFFF, hi=5; DIV a=32'h80000000, b=-1 -> lo=32'h80000000, hi=0.
REQ-038 start MULT, then start MTHI (a=32'h1234) in cycle 2 -> MTHI ignored, final hi = product; MFLO during busy -> c = old lo.
REQ-039 Assert rst_n low mid-DIV -> busy=0, hi=lo=0 asynchronously; a new MULT after release completes normally.
REQ-040 Regression at WIDTH=16, MUL_LAT=1, DIV_LAT=3: SRA a=4, b=16'h8000 -> c=16'hF800; the MULT result appears on the edge after accept.
